vga_multi_circle_ctrl: RTL and testbench

//  Parametrised successor of the single-circle VGA controller. Generates VGA timing from clk50

---
 rtl/vga_multi_circle_ctrl_pkg.sv | 26 ++
 rtl/vga_multi_circle_ctrl_if.sv | 25 ++
 rtl/vga_multi_circle_ctrl_timing_gen.sv | 63 ++++++
 rtl/vga_multi_circle_ctrl.sv | 130 +++++++++++++
 tb/tb_vga_multi_circle_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_multi_circle_ctrl_pkg.sv
// Shared constants, pixel colour type and squaring helper for the multi-circle VGA controller.
package vga_multi_circle_ctrl_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int RGB_W        = 24;
  localparam int CNT_W        = 10;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // 11-bit signed square; the magnitude never exceeds 1024, so 22 bits always hold it
  function automatic logic [21:0] sq11(input logic signed [10:0] v);
    logic signed [21:0] w;
    w = {{11{v[10]}}, v};
    return $unsigned(w * w);
  endfunction
endpackage

// File: rtl/vga_multi_circle_ctrl_if.sv
// Circle position inputs from the game logic and VGA DAC outputs, bundled as one bus.
interface vga_multi_circle_ctrl_if #(parameter int N_CIRCLES = 2);
  logic [N_CIRCLES*9-1:0]  circle_row;
  logic [N_CIRCLES*10-1:0] circle_col;
  logic [N_CIRCLES-1:0]    circle_en;
  logic [N_CIRCLES*24-1:0] circle_rgb;
  logic                    clk25;
  logic                    Hsync;
  logic                    Vsync;
  logic                    syncVGA;
  logic                    blankVGA;
  logic [7:0]              R;
  logic [7:0]              G;
  logic [7:0]              B;
  logic                    frame_start;

  modport master (
    output circle_row, circle_col, circle_en, circle_rgb,
    input  clk25, Hsync, Vsync, syncVGA, blankVGA, R, G, B, frame_start
  );
  modport slave (
    input  circle_row, circle_col, circle_en, circle_rgb,
    output clk25, Hsync, Vsync, syncVGA, blankVGA, R, G, B, frame_start
  );
endinterface

// File: rtl/vga_multi_circle_ctrl_timing_gen.sv
// Pixel-enable divider plus raster counters; sync/active are raw (undelayed) decodes.
module vga_timing_gen
  import vga_multi_circle_ctrl_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             pix_en_o,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o,
  output logic             hs_o,
  output logic             vs_o,
  output logic             active_o,
  output logic             eof_o
);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);

  logic             pix_q;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;

  always_comb begin
    h_d = (h_q == H_LAST) ? '0 : h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pix_q <= 1'b0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      pix_q <= ~pix_q;
      if (pix_q) begin
        h_q <= h_d;
        v_q <= v_d;
      end
    end
  end

  assign pix_en_o = pix_q;
  assign h_cnt_o  = h_q;
  assign v_cnt_o  = v_q;
  assign hs_o     = !((h_q >= HS_BEG) && (h_q < HS_END));
  assign vs_o     = !((v_q >= VS_BEG) && (v_q < VS_END));
  assign active_o = (h_q < H_ACT) && (v_q < V_ACT);
  assign eof_o    = pix_q && (h_q == H_LAST) && (v_q == V_LAST);
endmodule

// File: rtl/vga_multi_circle_ctrl.sv
// N filled circles over a background; positions are latched once per frame so moves never tear.
module vga_multi_circle_ctrl
  import vga_multi_circle_ctrl_pkg::*;
#(
  parameter int              H_ACTIVE  = DEF_H_ACTIVE,
  parameter int              H_FP      = DEF_H_FP,
  parameter int              H_SYNC    = DEF_H_SYNC,
  parameter int              H_BP      = DEF_H_BP,
  parameter int              V_ACTIVE  = DEF_V_ACTIVE,
  parameter int              V_FP      = DEF_V_FP,
  parameter int              V_SYNC    = DEF_V_SYNC,
  parameter int              V_BP      = DEF_V_BP,
  parameter int              N_CIRCLES = 2,
  parameter int              RADIUS    = 20,
  parameter logic [RGB_W-1:0] BG_RGB   = 24'h000000
) (
  input  logic                      clk50,
  input  logic                      rst,
  vga_multi_circle_ctrl_if.slave    bus
);
  localparam logic [22:0] R2 = 23'(RADIUS * RADIUS);

  logic             pix_en, hs_raw, vs_raw, act_raw, eof;
  logic [CNT_W-1:0] h_cnt, v_cnt;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk_i   (clk50),
    .rst_i   (rst),
    .pix_en_o(pix_en),
    .h_cnt_o (h_cnt),
    .v_cnt_o (v_cnt),
    .hs_o    (hs_raw),
    .vs_o    (vs_raw),
    .active_o(act_raw),
    .eof_o   (eof)
  );

  logic [N_CIRCLES-1:0][8:0] row_sh_q;
  logic [N_CIRCLES-1:0][9:0] col_sh_q;
  logic [N_CIRCLES-1:0]      en_sh_q;
  rgb_t [N_CIRCLES-1:0]      rgb_sh_q;
  logic                      fs_q;

  // Shadows change only on the last pixel of a frame, which is never visible
  always_ff @(posedge clk50) begin
    if (rst) begin
      row_sh_q <= '0;
      col_sh_q <= '0;
      en_sh_q  <= '0;
      rgb_sh_q <= '0;
      fs_q     <= 1'b0;
    end else begin
      fs_q <= eof;
      if (eof) begin
        row_sh_q <= bus.circle_row;
        col_sh_q <= bus.circle_col;
        en_sh_q  <= bus.circle_en;
        rgb_sh_q <= bus.circle_rgb;
      end
    end
  end

  logic [N_CIRCLES-1:0] hit;

  for (genvar i = 0; i < N_CIRCLES; i++) begin : g_circle
    logic signed [10:0] dx_q, dy_q;
    logic               en_q;
    logic [22:0]        dist_sq;

    always_ff @(posedge clk50) begin
      if (rst) begin
        dx_q <= '0;
        dy_q <= '0;
        en_q <= 1'b0;
      end else if (pix_en) begin
        dx_q <= {1'b0, h_cnt} - {1'b0, col_sh_q[i]};
        dy_q <= {1'b0, v_cnt} - {2'b0, row_sh_q[i]};
        en_q <= en_sh_q[i];
      end
    end

    assign dist_sq = {1'b0, sq11(dx_q)} + {1'b0, sq11(dy_q)};
    assign hit[i]  = en_q && (dist_sq <= R2);
  end

  logic hs_s1_q, vs_s1_q, act_s1_q, hs_q, vs_q, blank_q;
  rgb_t pix_d, rgb_d, rgb_q;

  // Walk from the highest index down so the lowest-index hit is the last writer
  always_comb begin
    pix_d = rgb_t'(BG_RGB);
    for (int i = N_CIRCLES - 1; i >= 0; i--) begin
      if (hit[i]) pix_d = rgb_sh_q[i];
    end
    rgb_d = act_s1_q ? pix_d : '0;
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      hs_s1_q  <= 1'b1;
      vs_s1_q  <= 1'b1;
      act_s1_q <= 1'b0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      blank_q  <= 1'b0;
      rgb_q    <= '0;
    end else if (pix_en) begin
      hs_s1_q  <= hs_raw;
      vs_s1_q  <= vs_raw;
      act_s1_q <= act_raw;
      hs_q     <= hs_s1_q;
      vs_q     <= vs_s1_q;
      blank_q  <= act_s1_q;
      rgb_q    <= rgb_d;
    end
  end

  assign bus.clk25       = pix_en;
  assign bus.Hsync       = hs_q;
  assign bus.Vsync       = vs_q;
  assign bus.syncVGA     = 1'b0;
  assign bus.blankVGA    = blank_q;
  assign bus.R           = rgb_q.r;
  assign bus.G           = rgb_q.g;
  assign bus.B           = rgb_q.b;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_vga_multi_circle_ctrl.sv
// Reduced-timing bench: a time-indexed raster model predicts every output on every clk50 cycle.
module tb_vga_multi_circle_ctrl;
  localparam int HA = 64, HFP = 4, HS = 8, HB = 4;
  localparam int VA = 48, VFP = 2, VS = 2, VB = 3;
  localparam int HT = HA + HFP + HS + HB;
  localparam int VT = VA + VFP + VS + VB;
  localparam int FT = HT * VT;
  localparam int NC = 3;
  localparam int RAD = 5;
  localparam logic [23:0] BG = 24'h102030;
  localparam logic [23:0] RED = 24'hFF0000, GRN = 24'h00FF00, BLU = 24'h0000FF;

  logic clk50 = 1'b0;
  logic rst;
  always #10 clk50 = ~clk50;

  vga_multi_circle_ctrl_if #(.N_CIRCLES(NC)) ifc ();

  vga_multi_circle_ctrl #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
    .N_CIRCLES(NC), .RADIUS(RAD), .BG_RGB(BG)
  ) dut (
    .clk50(clk50),
    .rst  (rst),
    .bus  (ifc)
  );

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  // Model: m_n = clk50 edges since reset; the frame's circles are whatever was presented at the load edge
  int          m_n = 0;
  int          m_row[NC];
  int          m_col[NC];
  bit          m_en[NC];
  logic [23:0] m_rgb[NC];

  always @(posedge clk50) begin
    if (rst) begin
      m_n <= 0;
      for (int i = 0; i < NC; i++) begin
        m_row[i] <= 0; m_col[i] <= 0; m_en[i] <= 0; m_rgb[i] <= '0;
      end
    end else begin
      m_n <= m_n + 1;
      if ((m_n + 1) % 2 == 0 && ((m_n + 1) / 2) % FT == 0) begin
        for (int i = 0; i < NC; i++) begin
          m_row[i] <= int'(ifc.circle_row[9*i +: 9]);
          m_col[i] <= int'(ifc.circle_col[10*i +: 10]);
          m_en[i]  <= ifc.circle_en[i];
          m_rgb[i] <= ifc.circle_rgb[24*i +: 24];
        end
      end
    end
  end

  function automatic logic [23:0] mdl_colour(int h, int v);
    for (int i = 0; i < NC; i++) begin
      int dx, dy;
      dx = h - m_col[i];
      dy = v - m_row[i];
      if (m_en[i] && dx*dx + dy*dy <= RAD*RAD) return m_rgb[i];
    end
    return BG;
  endfunction

  // Pixel index (h + v*HT) currently shown at the outputs, or -1 while the pipeline is still filling
  function automatic int out_pos();
    if (m_n / 2 < 2) return -1;
    return (m_n / 2 - 2) % FT;
  endfunction

  always @(negedge clk50) begin
    if (chk_on) begin
      int q, h, v;
      bit e_hs, e_vs, e_act, e_fs, e_clk;
      logic [23:0] e_rgb, a_rgb;
      q = out_pos();
      e_clk = (m_n % 2 == 1);
      if (q < 0) begin
        e_hs = 1; e_vs = 1; e_act = 0; e_rgb = '0;
      end else begin
        h = q % HT;
        v = q / HT;
        e_hs  = !(h >= HA + HFP && h < HA + HFP + HS);
        e_vs  = !(v >= VA + VFP && v < VA + VFP + VS);
        e_act = (h < HA) && (v < VA);
        e_rgb = e_act ? mdl_colour(h, v) : 24'h0;
      end
      e_fs  = (m_n > 0) && (m_n % 2 == 0) && ((m_n / 2) % FT == 0);
      a_rgb = {ifc.R, ifc.G, ifc.B};
      checks++;
      if (ifc.clk25 !== e_clk || ifc.Hsync !== e_hs || ifc.Vsync !== e_vs ||
          ifc.blankVGA !== e_act || ifc.frame_start !== e_fs || ifc.syncVGA !== 1'b0 ||
          a_rgb !== e_rgb) begin
        errors++;
        $display("FAIL cycle n=%0d pos=%0d: got clk25=%b hs=%b vs=%b blank=%b fs=%b sync=%b rgb=%h, want clk25=%b hs=%b vs=%b blank=%b fs=%b sync=0 rgb=%h",
                 m_n, q, ifc.clk25, ifc.Hsync, ifc.Vsync, ifc.blankVGA, ifc.frame_start,
                 ifc.syncVGA, a_rgb, e_clk, e_hs, e_vs, e_act, e_fs, e_rgb);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic set_circle(input int i, input logic [8:0] row, input logic [9:0] col,
                            input logic en, input logic [23:0] rgb);
    ifc.circle_row[9*i +: 9]   = row;
    ifc.circle_col[10*i +: 10] = col;
    ifc.circle_en[i]           = en;
    ifc.circle_rgb[24*i +: 24] = rgb;
  endtask

  task automatic check_pix(input int v, input int h, input logic [23:0] exp, input string nm);
    bit seen = 0;
    for (int c = 0; c < 3 * 2 * FT && !seen; c++) begin
      @(negedge clk50);
      if (m_n % 2 == 0 && out_pos() == h + v * HT) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: pixel (%0d,%0d) never reached", nm, v, h);
    end else if ({ifc.R, ifc.G, ifc.B} !== exp) begin
      errors++;
      $display("FAIL %s: pixel (%0d,%0d) rgb got %h want %h", nm, v, h, {ifc.R, ifc.G, ifc.B}, exp);
    end
  endtask

  task automatic wait_frame(input string nm);
    int c = 0;
    while (ifc.frame_start !== 1'b1 && c < 2 * FT + 10) begin
      @(negedge clk50);
      c++;
    end
    checks++;
    if (ifc.frame_start !== 1'b1) begin
      errors++;
      $display("FAIL %s: frame_start not seen within %0d cycles", nm, c);
    end
    @(negedge clk50);
  endtask

  initial begin
    int cnt, lo, hi;
    rst = 1'b1;
    ifc.circle_row = '0;
    ifc.circle_col = '0;
    ifc.circle_en  = '0;
    ifc.circle_rgb = '0;
    @(posedge clk50);
    chk_on = 1;
    repeat (3) @(negedge clk50);
    chk("reset_hsync", 32'(ifc.Hsync), 32'd1);
    chk("reset_vsync", 32'(ifc.Vsync), 32'd1);
    chk("reset_blank", 32'(ifc.blankVGA), 32'd0);
    chk("reset_rgb", 32'({ifc.R, ifc.G, ifc.B}), 32'd0);
    chk("reset_clk25", 32'(ifc.clk25), 32'd0);
    chk("reset_fs", 32'(ifc.frame_start), 32'd0);

    set_circle(0, 9'd20, 10'd30, 1'b1, RED);
    set_circle(1, 9'd20, 10'd36, 1'b1, GRN);
    set_circle(2, 9'd45, 10'd62, 1'b1, BLU);
    rst = 1'b0;

    cnt = 0;
    do begin
      @(negedge clk50);
      cnt++;
    end while (ifc.Hsync !== 1'b0 && cnt < 2000);
    chk("first_hsync_fall", 32'(cnt), 32'(2 * (HA + HFP + 2)));
    lo = 0;
    while (ifc.Hsync === 1'b0 && lo < 1000) begin lo++; @(negedge clk50); end
    hi = 0;
    while (ifc.Hsync === 1'b1 && hi < 1000) begin hi++; @(negedge clk50); end
    chk("hsync_low_width", 32'(lo), 32'(2 * HS));
    chk("hsync_period", 32'(lo + hi), 32'(2 * HT));
    cnt = 0;
    while (ifc.Vsync !== 1'b0 && cnt < 2 * FT) begin cnt++; @(negedge clk50); end
    lo = 0;
    while (ifc.Vsync === 1'b0 && lo < 4 * FT) begin lo++; @(negedge clk50); end
    chk("vsync_low_width", 32'(lo), 32'(2 * VS * HT));

    wait_frame("load1");
    check_pix(20, 33, RED, "prio_both_hit");
    check_pix(20, 35, RED, "radius_edge");
    check_pix(20, 36, GRN, "second_circle");
    check_pix(20, 41, GRN, "second_edge");
    check_pix(25, 30, RED, "vert_edge");
    check_pix(26, 30, BG,  "vert_outside");
    check_pix(45, 66, 24'h0, "clip_blank");
    check_pix(47, 63, BLU, "clip_visible");

    ifc.circle_en[0] = 1'b0;
    wait_frame("load2");
    check_pix(20, 30, BG,  "en0_cleared_bg");
    check_pix(20, 33, GRN, "en0_cleared_green");
    set_circle(1, 9'd35, 10'd20, 1'b1, GRN);
    check_pix(35, 20, BG, "no_tear_same_frame");
    wait_frame("load3");
    check_pix(20, 36, BG,  "moved_old_spot");
    check_pix(35, 20, GRN, "moved_new_spot");

    for (int j = 0; j < 40; j++) begin
      repeat ($urandom_range(500, 50)) @(negedge clk50);
      for (int i = 0; i < NC; i++) begin
        logic [8:0] r;
        logic [9:0] c;
        r = ($urandom_range(3, 0) == 0) ? 9'($urandom) : 9'($urandom_range(60, 0));
        c = ($urandom_range(3, 0) == 0) ? 10'($urandom) : 10'($urandom_range(75, 0));
        set_circle(i, r, c, 1'($urandom_range(3, 0) != 0), 24'($urandom));
      end
    end

    cnt = 0;
    do begin
      @(negedge clk50);
      cnt++;
    end while (out_pos() != 30 * HT && cnt < 2 * FT + 10);
    chk("reach_row30", 32'(out_pos()), 32'(30 * HT));
    rst = 1'b1;
    @(negedge clk50);
    chk("midreset_hsync", 32'(ifc.Hsync), 32'd1);
    chk("midreset_blank", 32'(ifc.blankVGA), 32'd0);
    chk("midreset_rgb", 32'({ifc.R, ifc.G, ifc.B}), 32'd0);
    chk("midreset_clk25", 32'(ifc.clk25), 32'd0);
    rst = 1'b0;
    check_pix(0, 2, BG, "post_reset_bg");
    wait_frame("load_after_reset");
    repeat (400) @(negedge clk50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
